// File: rtl/wb_pipe_stage.sv
// MEM/WB pipeline register with late-bus forwarding, a retire counter and a stall watchdog.
// Flow commands come from the hazard unit; the stage holds at most one entry.
//
// flag state   | meaning
// -------------+-------------------------------------------------------------
// FLAG_WORK    | last edge loaded the stage; late_o forwards late_i
// FLAG_STOP    | stage is stalled; late_o replays the captured late value
// FLAG_REFRESH | stage was flushed or reset; late_o reads zero
module wb_pipe_stage #(
   parameter int DATA_W    = 146,
   parameter int LATE_W    = 32,
   parameter int CNT_W     = 64,
   parameter int STALL_MAX = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        flow_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [LATE_W-1:0] late_i,
   input  logic              clr_cnt_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [LATE_W-1:0] late_o,
   output logic [CNT_W-1:0]  retire_cnt_o,
   output logic              stall_timeout_o
);

   localparam int RUN_W = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);

   typedef enum logic [1:0] {
      FLAG_WORK    = 2'b00,
      FLAG_STOP    = 2'b01,
      FLAG_REFRESH = 2'b10
   } flag_t;

   flag_t             flag;
   logic [LATE_W-1:0] late_hold;
   logic [RUN_W-1:0]  stall_run;
   logic              is_work;
   logic              is_stop;

   assign is_work = (flow_i == 2'b00);
   assign is_stop = (flow_i == 2'b01);

   always_comb begin
      late_o = '0;
      case (flag)
         FLAG_WORK: late_o = late_i;
         FLAG_STOP: late_o = late_hold;
         default:   late_o = '0;
      endcase
   end

   // Payload, valid, flow flag and the late-value capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_o   <= 1'b0;
         data_o    <= '0;
         flag      <= FLAG_REFRESH;
         late_hold <= '0;
      end else begin
         late_hold <= late_o;
         if (is_work) begin
            valid_o <= valid_i;
            data_o  <= data_i;
            flag    <= FLAG_WORK;
         end else if (is_stop) begin
            flag    <= FLAG_STOP;
         end else begin
            valid_o <= 1'b0;
            data_o  <= '0;
            flag    <= FLAG_REFRESH;
         end
      end
   end

   // Only a valid entry leaving through WORK retires; a REFRESH is a kill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retire_cnt_o <= '0;
      end else if (clr_cnt_i) begin
         retire_cnt_o <= '0;
      end else if (is_work && valid_o) begin
         retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      end
   end

   // Timeout fires once, on the edge the saturating run counter reaches STALL_MAX.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_run       <= '0;
         stall_timeout_o <= 1'b0;
      end else if (clr_cnt_i) begin
         stall_run       <= '0;
         stall_timeout_o <= 1'b0;
      end else if (is_stop) begin
         if (stall_run != RUN_W'(STALL_MAX))
            stall_run <= stall_run + RUN_W'(1);
         if (stall_run == RUN_W'(STALL_MAX - 1))
            stall_timeout_o <= 1'b1;
      end else begin
         stall_run <= '0;
      end
   end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: directed scenarios then random flow/valid/clear/reset traffic,
// all compared against a cycle-level behavioural model of the stage.
module tb_wb_pipe_stage;

   localparam int DW        = 146;
   localparam int LW        = 32;
   localparam int CW        = 4;
   localparam int STALL_MAX = 4;
   localparam logic [1:0] WORK = 2'b00, STOP = 2'b01, REFR = 2'b10, REFR3 = 2'b11;

   logic          clk;
   logic          rst_n;
   logic [1:0]    flow_i;
   logic          valid_i;
   logic [DW-1:0] data_i;
   logic [LW-1:0] late_i;
   logic          clr_cnt_i;
   logic          valid_o;
   logic [DW-1:0] data_o;
   logic [LW-1:0] late_o;
   logic [CW-1:0] retire_cnt_o;
   logic          stall_timeout_o;

   wb_pipe_stage #(.DATA_W(DW), .LATE_W(LW), .CNT_W(CW), .STALL_MAX(STALL_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .flow_i(flow_i), .valid_i(valid_i), .data_i(data_i),
      .late_i(late_i), .clr_cnt_i(clr_cnt_i), .valid_o(valid_o), .data_o(data_o),
      .late_o(late_o), .retire_cnt_o(retire_cnt_o), .stall_timeout_o(stall_timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // model: mode 0 = last edge loaded, 1 = stalled, 2 = flushed
   int            m_mode;
   bit            m_valid;
   logic [DW-1:0] m_data;
   int            m_cnt;
   int            m_run;
   bit            m_timeout;
   logic [LW-1:0] m_held;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [LW-1:0] exp_late(input logic [LW-1:0] l);
      if (m_mode == 0) return l;
      if (m_mode == 1) return m_held;
      return '0;
   endfunction

   task automatic model_edge(input logic r, input logic [1:0] f, input logic v,
                             input logic [DW-1:0] d, input logic [LW-1:0] l, input logic c);
      if (!r) begin
         m_mode = 2; m_valid = 0; m_data = '0; m_cnt = 0; m_run = 0; m_timeout = 0; m_held = '0;
         return;
      end
      m_held = exp_late(l);
      if (f == WORK && m_valid) m_cnt = (m_cnt + 1) % (1 << CW);
      if (f == STOP) begin
         m_run++;
         if (m_run == STALL_MAX) m_timeout = 1;
      end else begin
         m_run = 0;
      end
      if (c) begin
         m_cnt = 0; m_run = 0; m_timeout = 0;
      end
      case (f)
         WORK:    begin m_mode = 0; m_valid = v; m_data = d; end
         STOP:    m_mode = 1;
         default: begin m_mode = 2; m_valid = 0; m_data = '0; end
      endcase
   endtask

   // Drive one cycle at the negedge, check the outputs, then advance the model at posedge.
   task automatic step(input logic r, input logic [1:0] f, input logic v,
                       input logic [DW-1:0] d, input logic [LW-1:0] l, input logic c);
      rst_n = r; flow_i = f; valid_i = v; data_i = d; late_i = l; clr_cnt_i = c;
      #1;
      chk("valid_o", 256'(valid_o), 256'(m_valid));
      chk("data_o", 256'(data_o), 256'(m_data));
      chk("late_o", 256'(late_o), 256'(exp_late(l)));
      chk("retire_cnt_o", 256'(retire_cnt_o), 256'(m_cnt));
      chk("stall_timeout_o", 256'(stall_timeout_o), 256'(m_timeout));
      @(posedge clk);
      model_edge(r, f, v, d, l, c);
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] x;
      for (int i = 0; i < DW; i += 32) x[i +: 32] = $urandom;
      return x;
   endfunction

   initial begin
      rst_n = 0; flow_i = WORK; valid_i = 0; data_i = '0; late_i = '0; clr_cnt_i = 0;
      @(negedge clk);
      @(posedge clk); model_edge(0, WORK, 0, '0, '0, 0);
      @(posedge clk); model_edge(0, WORK, 0, '0, '0, 0);
      @(negedge clk);

      // reset then idle
      step(1, WORK, 0, '0, '0, 0);
      step(1, WORK, 0, '0, '0, 0);
      chk("idle_valid", 256'(valid_o), 256'(0));
      chk("idle_late", 256'(late_o), 256'(0));

      // load, late pass-through, stall hold, retire on next WORK
      step(1, WORK, 1, DW'(16'h1234), '0, 0);
      step(1, STOP, 0, '0, 32'hDEADBEEF, 0);
      chk("stop_hold_data", 256'(data_o), 256'(16'h1234));
      step(1, STOP, 0, '0, 32'h55555555, 0);
      chk("stop_late_held", 256'(late_o), 256'(32'hDEADBEEF));
      step(1, STOP, 0, '0, 32'h55555555, 0);
      step(1, WORK, 0, '0, 32'h55555555, 0);
      chk("retire_after_stall", 256'(retire_cnt_o), 256'(1));

      // refresh kill, both encodings
      step(1, WORK, 1, DW'(8'hAA), '0, 0);
      step(1, REFR, 0, '0, 32'h11111111, 0);
      chk("kill_valid", 256'(valid_o), 256'(0));
      chk("kill_cnt", 256'(retire_cnt_o), 256'(1));
      step(1, WORK, 1, DW'(8'hBB), 32'h22222222, 0);
      step(1, REFR3, 0, '0, 32'h33333333, 0);
      chk("kill3_data", 256'(data_o), 256'(0));
      step(1, WORK, 0, '0, 32'h44444444, 0);

      // watchdog: four STOP edges, sticky through WORK, then clear
      for (int i = 0; i < 4; i++) step(1, STOP, 0, '0, $urandom, 0);
      chk("wdog_set", 256'(stall_timeout_o), 256'(1));
      step(1, WORK, 0, '0, $urandom, 0);
      chk("wdog_sticky", 256'(stall_timeout_o), 256'(1));
      step(1, WORK, 0, '0, $urandom, 1);
      chk("wdog_clr", 256'(stall_timeout_o), 256'(0));
      chk("cnt_clr", 256'(retire_cnt_o), 256'(0));

      // wrap 15->0 after 16 retires, then clear beats a retire
      for (int i = 0; i < 17; i++) step(1, WORK, 1, rnd_data(), $urandom, 0);
      chk("cnt_wrap", 256'(retire_cnt_o), 256'(0));
      step(1, WORK, 1, rnd_data(), $urandom, 0);
      step(1, WORK, 1, rnd_data(), $urandom, 1);
      chk("clr_priority", 256'(retire_cnt_o), 256'(0));

      // reset mid-STOP
      step(1, STOP, 0, '0, $urandom, 0);
      step(1, STOP, 0, '0, $urandom, 0);
      step(0, STOP, 1, rnd_data(), $urandom, 0);
      chk("rst_valid", 256'(valid_o), 256'(0));
      chk("rst_data", 256'(data_o), 256'(0));
      chk("rst_timeout", 256'(stall_timeout_o), 256'(0));
      step(1, STOP, 0, '0, $urandom, 0);

      // random traffic, STOP-heavy so the watchdog trips
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] f;
         logic r, c;
         f = ($urandom_range(0, 2) == 0) ? STOP : 2'($urandom_range(0, 3));
         r = ($urandom_range(0, 99) != 0);
         c = ($urandom_range(0, 39) == 0);
         step(r, f, 1'($urandom), rnd_data(), $urandom, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
